digit_serial_addsub: RTL and testbench

//  Parametrised, multi-cycle successor to the single-bit FULLADD cell: a digit-serial
//  two's-complement adder/subtractor that processes DIGIT bits per clock, LSB digit first.
//  It serves FPU mantissa/exponent paths where area matters more than latency.
//  One carry flop is reused across digits; the operation is started and completed with a

---
 rtl/digit_serial_addsub_if.sv | 25 ++
 rtl/digit_serial_addsub.sv | 121 ++++++++++++
 tb/tb_digit_serial_addsub.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// The master side issues requests and the slave side is the arithmetic unit.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start_i;
    logic             sub_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;

    modport master (
        output start_i, sub_i, a_i, b_i,
        input  busy_o, done_o, sum_o, cout_o, ovf_o
    );

    modport slave (
        input  start_i, sub_i, a_i, b_i,
        output busy_o, done_o, sum_o, cout_o, ovf_o
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB digit first,
// one carry flop reused across digits, START/BUSY/DONE handshake.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    digit_serial_addsub_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT:0]   digSum;
    logic             msbCarryIn;
    logic [WIDTH-1:0] opANext;
    logic             lastDigit;

    assign digSum     = {1'b0, opA_q[DIGIT-1:0]} + {1'b0, opB_q[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry_q};
    assign msbCarryIn = digSum[DIGIT-1] ^ opA_q[DIGIT-1] ^ opB_q[DIGIT-1];
    assign lastDigit  = (cnt_q == CW'(NDIG - 1));

    // Result digits are shifted into the top of the A register as A's digits drain out,
    // so after NDIG steps opA_q holds the complete sum.
    if (DIGIT == WIDTH) begin : gFullDigit
        assign opANext = digSum[DIGIT-1:0];
    end else begin : gPartDigit
        assign opANext = {digSum[DIGIT-1:0], opA_q[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, FIN: begin
                if (bus.start_i) begin
                    opA_d   = bus.a_i;
                    opB_d   = bus.b_i ^ {WIDTH{bus.sub_i}};
                    carry_d = bus.sub_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                opA_d   = opANext;
                opB_d   = opB_q >> DIGIT;
                carry_d = digSum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (lastDigit) begin
                    sum_d   = opANext;
                    cout_d  = digSum[DIGIT];
                    ovf_d   = digSum[DIGIT] ^ msbCarryIn;
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.sum_o  = sum_q;
    assign bus.cout_o = cout_q;
    assign bus.ovf_o  = ovf_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench for digit_serial_addsub: directed vector table on W=16/D=4,
// hand-written handshake corner cases, and random sweeps on three other geometries.
module tb_digit_serial_addsub;
    logic clk = 1'b0;
    logic rst;
    int   testsRun    = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    digit_serial_addsub_if #(.WIDTH(16)) ifMain ();
    digit_serial_addsub_if #(.WIDTH(8))  if81 ();
    digit_serial_addsub_if #(.WIDTH(8))  if88 ();
    digit_serial_addsub_if #(.WIDTH(32)) if328 ();

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dutMain (.clk_i(clk), .rst_i(rst), .bus(ifMain));
    digit_serial_addsub #(.WIDTH(8),  .DIGIT(1)) dut81   (.clk_i(clk), .rst_i(rst), .bus(if81));
    digit_serial_addsub #(.WIDTH(8),  .DIGIT(8)) dut88   (.clk_i(clk), .rst_i(rst), .bus(if88));
    digit_serial_addsub #(.WIDTH(32), .DIGIT(8)) dut328  (.clk_i(clk), .rst_i(rst), .bus(if328));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] expSum;
        logic        expCout;
        logic        expOvf;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic st, input logic sb,
                                 input logic [31:0] a, input logic [31:0] b);
        case (which)
            0: begin ifMain.start_i = st; ifMain.sub_i = sb; ifMain.a_i = a[15:0]; ifMain.b_i = b[15:0]; end
            1: begin if81.start_i = st;   if81.sub_i = sb;   if81.a_i = a[7:0];    if81.b_i = b[7:0];    end
            2: begin if88.start_i = st;   if88.sub_i = sb;   if88.a_i = a[7:0];    if88.b_i = b[7:0];    end
            default: begin if328.start_i = st; if328.sub_i = sb; if328.a_i = a; if328.b_i = b; end
        endcase
    endtask

    function automatic int widthOf(input int which);
        case (which)
            0: return 16;
            1: return 8;
            2: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int digitOf(input int which);
        case (which)
            0: return 4;
            1: return 1;
            2: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic logic getDone(input int which);
        case (which)
            0: return ifMain.done_o;
            1: return if81.done_o;
            2: return if88.done_o;
            default: return if328.done_o;
        endcase
    endfunction

    function automatic logic getBusy(input int which);
        case (which)
            0: return ifMain.busy_o;
            1: return if81.busy_o;
            2: return if88.busy_o;
            default: return if328.busy_o;
        endcase
    endfunction

    function automatic logic [31:0] getSum(input int which);
        case (which)
            0: return {16'd0, ifMain.sum_o};
            1: return {24'd0, if81.sum_o};
            2: return {24'd0, if88.sum_o};
            default: return if328.sum_o;
        endcase
    endfunction

    function automatic logic getCout(input int which);
        case (which)
            0: return ifMain.cout_o;
            1: return if81.cout_o;
            2: return if88.cout_o;
            default: return if328.cout_o;
        endcase
    endfunction

    function automatic logic getOvf(input int which);
        case (which)
            0: return ifMain.ovf_o;
            1: return if81.ovf_o;
            2: return if88.ovf_o;
            default: return if328.ovf_o;
        endcase
    endfunction

    // Whole-word reference: signed overflow when both addends share a sign the sum lacks.
    task automatic refModel(input int w, input logic [31:0] a, input logic [31:0] b, input logic sub,
                            output logic [31:0] sum, output logic cout, output logic ovf);
        logic [63:0] mask;
        logic [63:0] bb;
        logic [63:0] full;
        logic [31:0] bInv;
        mask = (64'd1 << w) - 64'd1;
        bInv = sub ? ~b : b;
        bb   = {32'd0, bInv} & mask;
        full = ({32'd0, a} & mask) + bb + {63'd0, sub};
        sum  = full[31:0] & mask[31:0];
        cout = full[w];
        ovf  = (a[w-1] == bb[w-1]) && (sum[w-1] != a[w-1]);
    endtask

    // Called at a negedge; returns at the negedge where DONE is seen (or after a timeout).
    task automatic runOp(input int which, input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output logic [31:0] sum, output logic cout, output logic ovf,
                         output int lat, output int busyCycles, output logic holdOk);
        logic [31:0] prevSum;
        prevSum    = getSum(which);
        holdOk     = 1'b1;
        lat        = 0;
        busyCycles = 0;
        applyStimulus(which, 1'b1, sub, a, b);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        applyStimulus(which, 1'b0, ~sub, ~a, ~b);
        while (!getDone(which) && lat < 64) begin
            if (getBusy(which)) busyCycles++;
            if (getSum(which) !== prevSum) holdOk = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        sum  = getSum(which);
        cout = getCout(which);
        ovf  = getOvf(which);
    endtask

    initial begin
        vec_t        vecs[10];
        logic [31:0] sum, expSum, ra, rb;
        logic        cout, ovf, expCout, expOvf, holdOk, rs;
        int          lat, busyCycles, strayDone, strayBusy, w, nd;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h1000, 16'h2000, 1'b1, 16'hF000, 1'b0, 1'b0};
        vecs[8] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus(k, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset busy", {31'd0, ifMain.busy_o}, 32'd0);
        checkOutput("reset done", {31'd0, ifMain.done_o}, 32'd0);
        checkOutput("reset sum",  {16'd0, ifMain.sum_o},  32'd0);
        checkOutput("reset cout", {31'd0, ifMain.cout_o}, 32'd0);
        checkOutput("reset ovf",  {31'd0, ifMain.ovf_o},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            runOp(0, {16'd0, vecs[i].a}, {16'd0, vecs[i].b}, vecs[i].sub, sum, cout, ovf, lat, busyCycles, holdOk);
            checkOutput($sformatf("vec%0d sum", i),     sum,                    {16'd0, vecs[i].expSum});
            checkOutput($sformatf("vec%0d cout", i),    {31'd0, cout},          {31'd0, vecs[i].expCout});
            checkOutput($sformatf("vec%0d ovf", i),     {31'd0, ovf},           {31'd0, vecs[i].expOvf});
            checkOutput($sformatf("vec%0d latency", i), lat,                    32'd5);
            checkOutput($sformatf("vec%0d busy", i),    busyCycles,             32'd4);
            checkOutput($sformatf("vec%0d hold", i),    {31'd0, holdOk},        32'd1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d done pulse", i), {31'd0, ifMain.done_o}, 32'd0);
        end

        // A second START during RUN must be dropped, not queued.
        applyStimulus(0, 1'b1, 1'b0, 32'h1234, 32'h0FCD);
        @(posedge clk); @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); @(negedge clk);
        applyStimulus(0, 1'b1, 1'b1, 32'hFFFF, 32'hFFFF);
        @(posedge clk); @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        lat = 3;
        while (!ifMain.done_o && lat < 64) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        checkOutput("ignored start latency", lat, 32'd5);
        checkOutput("ignored start sum",  {16'd0, ifMain.sum_o},  32'h2201);
        checkOutput("ignored start cout", {31'd0, ifMain.cout_o}, 32'd0);
        strayDone = 0;
        strayBusy = 0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (ifMain.done_o) strayDone++;
            if (ifMain.busy_o) strayBusy++;
        end
        checkOutput("ignored start stray done", strayDone, 32'd0);
        checkOutput("ignored start stray busy", strayBusy, 32'd0);

        // START held in FIN launches the next operation immediately.
        runOp(0, 32'h1234, 32'h0FCD, 1'b0, sum, cout, ovf, lat, busyCycles, holdOk);
        checkOutput("b2b first sum", sum, 32'h2201);
        checkOutput("b2b in FIN", {31'd0, ifMain.done_o}, 32'd1);
        runOp(0, 32'h7FFF, 32'h0001, 1'b0, sum, cout, ovf, lat, busyCycles, holdOk);
        checkOutput("b2b second latency", lat, 32'd5);
        checkOutput("b2b second sum", sum, 32'h8000);
        checkOutput("b2b second ovf", {31'd0, ovf}, 32'd1);
        checkOutput("b2b second hold", {31'd0, holdOk}, 32'd1);

        // Reset during the second RUN cycle aborts the operation and clears the results.
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 32'h1234, 32'h0FCD);
        @(posedge clk); @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort busy", {31'd0, ifMain.busy_o}, 32'd0);
        checkOutput("abort sum",  {16'd0, ifMain.sum_o},  32'd0);
        checkOutput("abort ovf",  {31'd0, ifMain.ovf_o},  32'd0);
        checkOutput("abort done", {31'd0, ifMain.done_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        strayDone = 0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (ifMain.done_o) strayDone++;
        end
        checkOutput("abort stray done", strayDone, 32'd0);
        runOp(0, 32'h00FF, 32'h0F01, 1'b0, sum, cout, ovf, lat, busyCycles, holdOk);
        checkOutput("post-abort sum", sum, 32'h1000);
        checkOutput("post-abort latency", lat, 32'd5);
        @(negedge clk);

        for (int which = 1; which < 4; which++) begin
            w  = widthOf(which);
            nd = w / digitOf(which);
            for (int k = 0; k < 1000; k++) begin
                ra = $urandom;
                rb = $urandom;
                rs = 1'($urandom_range(0, 1));
                if (k == 0) begin ra = (32'hFFFF_FFFF >> (33 - w)); rb = 32'd1; rs = 1'b0; end
                if (k == 1) begin ra = 32'd1 << (w - 1); rb = 32'd1; rs = 1'b1; end
                if (w < 32) begin
                    ra = ra & ((32'd1 << w) - 32'd1);
                    rb = rb & ((32'd1 << w) - 32'd1);
                end
                runOp(which, ra, rb, rs, sum, cout, ovf, lat, busyCycles, holdOk);
                refModel(w, ra, rb, rs, expSum, expCout, expOvf);
                checkOutput($sformatf("W%0d/D%0d op%0d sum", w, digitOf(which), k),  sum, expSum);
                checkOutput($sformatf("W%0d/D%0d op%0d cout", w, digitOf(which), k), {31'd0, cout}, {31'd0, expCout});
                checkOutput($sformatf("W%0d/D%0d op%0d ovf", w, digitOf(which), k),  {31'd0, ovf},  {31'd0, expOvf});
                checkOutput($sformatf("W%0d/D%0d op%0d latency", w, digitOf(which), k), lat, nd + 1);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
